// File: rtl/width_lane_deserializer_if.sv
// Byte-side and lane-side handshake bundle for width_lane_deserializer.
// slave is the deserializer's view; master is the producer/consumer environment.
interface width_lane_deserializer_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_16bit;
  logic [7:0]  data_8bit;
  logic [3:0]  data_4bit;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  data_16bit,
    input  data_8bit,
    input  data_4bit,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output data_16bit,
    output data_8bit,
    output data_4bit,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/width_lane_deserializer.sv
// Assembles 4-byte frames from a byte stream onto 16/8/4-bit lanes behind a one-entry output register.
// Optional WIDTH_LANE_CHECKSUM_EN adds a fifth XOR checksum byte (state CK) and a chk_err pulse.
module width_lane_deserializer #(
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  width_lane_deserializer_if.slave bus,
  output logic                   fmt_err,
  output logic [FRAME_CNT_W-1:0] frame_count
`ifdef WIDTH_LANE_CHECKSUM_EN
  ,
  output logic                   chk_err
`endif
);

  localparam logic [2:0] B0 = 3'd0;
  localparam logic [2:0] B1 = 3'd1;
  localparam logic [2:0] B2 = 3'd2;
  localparam logic [2:0] B3 = 3'd3;
`ifdef WIDTH_LANE_CHECKSUM_EN
  localparam logic [2:0] CK = 3'd4;
  localparam logic [2:0] LAST = CK;
`else
  localparam logic [2:0] LAST = B3;
`endif

  localparam logic [FRAME_CNT_W-1:0] CNT_INC = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  function automatic logic nib_bad(input logic [7:0] b);
    return b[7:4] != 4'h0;
  endfunction

`ifdef WIDTH_LANE_CHECKSUM_EN
  function automatic logic [7:0] frame_xor(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [7:0] d);
    return a ^ b ^ c ^ d;
  endfunction
`endif

  logic [2:0]             state_p0;
  logic [2:0]             state_nxt;
  logic [7:0]             b0_p0;
  logic [7:0]             b1_p0;
  logic [7:0]             b2_p0;
`ifdef WIDTH_LANE_CHECKSUM_EN
  logic [7:0]             b3_p0;
  logic                   chk_err_p1;
`endif
  logic [15:0]            d16_p1;
  logic [7:0]             d8_p1;
  logic [3:0]             d4_p1;
  logic                   vld_p1;
  logic                   fmt_err_p1;
  logic [FRAME_CNT_W-1:0] cnt_p1;

  logic                   can_load;
  logic                   in_rdy;
  logic                   byte_xfer;
  logic                   frame_xfer;
  logic                   frame_done;
  logic                   ck_match;
  logic                   load;
  logic [7:0]             last_byte;

  // Completing state may only accept its byte when the output slot is free or draining now.
  assign can_load   = !vld_p1 || bus.out_ready;
  assign in_rdy     = (state_p0 == LAST) ? can_load : 1'b1;
  assign byte_xfer  = bus.in_valid && in_rdy;
  assign frame_xfer = vld_p1 && bus.out_ready;
  assign frame_done = byte_xfer && (state_p0 == LAST);

`ifdef WIDTH_LANE_CHECKSUM_EN
  assign last_byte = b3_p0;
  assign ck_match  = (bus.in_data == frame_xor(b0_p0, b1_p0, b2_p0, b3_p0));
`else
  assign last_byte = bus.in_data;
  assign ck_match  = 1'b1;
`endif

  assign load = frame_done && ck_match;

  always_comb begin
    state_nxt = state_p0;
    if (byte_xfer) begin
      case (state_p0)
        B0:      state_nxt = B1;
        B1:      state_nxt = B2;
        B2:      state_nxt = B3;
`ifdef WIDTH_LANE_CHECKSUM_EN
        B3:      state_nxt = CK;
        CK:      state_nxt = B0;
`else
        B3:      state_nxt = B0;
`endif
        default: state_nxt = B0;
      endcase
    end
  end

  // Stage 0: byte staging, no reset needed since the FSM restarts at B0 and overwrites it.
  always_ff @(posedge clk) begin
    if (byte_xfer) begin
      case (state_p0)
        B0:      b0_p0 <= bus.in_data;
        B1:      b1_p0 <= bus.in_data;
        B2:      b2_p0 <= bus.in_data;
`ifdef WIDTH_LANE_CHECKSUM_EN
        B3:      b3_p0 <= bus.in_data;
`endif
        default: ;
      endcase
    end
  end

  // Stage 1: output register, loaded only on a completed (and, if enabled, verified) frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= B0;
      vld_p1     <= 1'b0;
      fmt_err_p1 <= 1'b0;
      cnt_p1     <= '0;
      d16_p1     <= '0;
      d8_p1      <= '0;
      d4_p1      <= '0;
`ifdef WIDTH_LANE_CHECKSUM_EN
      chk_err_p1 <= 1'b0;
`endif
    end else begin
      state_p0   <= state_nxt;
      fmt_err_p1 <= load && nib_bad(last_byte);
`ifdef WIDTH_LANE_CHECKSUM_EN
      chk_err_p1 <= frame_done && !ck_match;
`endif
      if (frame_xfer) begin
        cnt_p1 <= cnt_p1 + CNT_INC;
      end
      if (load) begin
        vld_p1 <= 1'b1;
        d16_p1 <= {b1_p0, b0_p0};
        d8_p1  <= b2_p0;
        d4_p1  <= last_byte[3:0];
      end else if (frame_xfer) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = vld_p1;
  assign bus.data_16bit = d16_p1;
  assign bus.data_8bit  = d8_p1;
  assign bus.data_4bit  = d4_p1;
  assign fmt_err        = fmt_err_p1;
  assign frame_count    = cnt_p1;
`ifdef WIDTH_LANE_CHECKSUM_EN
  assign chk_err        = chk_err_p1;
`endif

endmodule

// File: tb/tb_width_lane_deserializer.sv
// Bench for width_lane_deserializer: directed scenarios then random traffic against a frame-level model.
module tb_width_lane_deserializer;
  localparam int CW = 4;
`ifdef WIDTH_LANE_CHECKSUM_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  width_lane_deserializer_if bus ();
  logic          fmt_err;
  logic [CW-1:0] frame_count;
`ifdef WIDTH_LANE_CHECKSUM_EN
  logic          chk_err;
`endif

  width_lane_deserializer #(.FRAME_CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fmt_err     (fmt_err),
    .frame_count (frame_count)
`ifdef WIDTH_LANE_CHECKSUM_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: bytes collected so far, the held frame, and a delivery count.
  logic [7:0]  part_q[$];
  logic [7:0]  tx_q[$];
  bit          m_vld;
  logic [15:0] m_d16;
  logic [7:0]  m_d8;
  logic [3:0]  m_d4;
  int unsigned m_cnt;
  bit          m_fmt;
  bit          m_chk;

  task automatic model_reset();
    part_q.delete();
    m_vld = 0; m_d16 = '0; m_d8 = '0; m_d4 = '0;
    m_cnt = 0; m_fmt = 0; m_chk = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", bus.out_valid, m_vld);
    check("data_16bit", bus.data_16bit, m_d16);
    check("data_8bit", bus.data_8bit, m_d8);
    check("data_4bit", bus.data_4bit, m_d4);
    check("fmt_err", fmt_err, m_fmt);
    check("frame_count", frame_count, m_cnt % (1 << CW));
`ifdef WIDTH_LANE_CHECKSUM_EN
    check("chk_err", chk_err, m_chk);
`endif
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit ordy, output bit taken);
    bit         exp_rdy;
    bit         ok;
    logic [7:0] b3;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    exp_rdy = (part_q.size() == FLEN - 1) ? (!m_vld || ordy) : 1'b1;
    check("in_ready", bus.in_ready, exp_rdy);
    taken = v && exp_rdy;
    m_fmt = 0;
    m_chk = 0;
    if (m_vld && ordy) begin
      m_cnt++;
      m_vld = 0;
    end
    if (taken) begin
      part_q.push_back(d);
      if (part_q.size() == FLEN) begin
        ok = 1;
`ifdef WIDTH_LANE_CHECKSUM_EN
        ok = (part_q[4] == (part_q[0] ^ part_q[1] ^ part_q[2] ^ part_q[3]));
`endif
        if (ok) begin
          b3    = part_q[3];
          m_vld = 1;
          m_d16 = {part_q[1], part_q[0]};
          m_d8  = part_q[2];
          m_d4  = b3[3:0];
          m_fmt = (b3[7:4] != 4'h0);
        end else begin
          m_chk = 1;
        end
        part_q.delete();
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    check("rst_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input bit corrupt);
    tx_q.push_back(b0);
    tx_q.push_back(b1);
    tx_q.push_back(b2);
    tx_q.push_back(b3);
`ifdef WIDTH_LANE_CHECKSUM_EN
    tx_q.push_back((b0 ^ b1 ^ b2 ^ b3) ^ (corrupt ? 8'h5A : 8'h00));
`else
    if (corrupt) tx_q.push_back(8'h00);
    if (corrupt) void'(tx_q.pop_back());
`endif
  endtask

  task automatic send_tx(input bit ordy, input int keep);
    bit taken;
    int guard = 0;
    while (tx_q.size() > keep && guard < 200) begin
      cycle(1'b1, tx_q[0], ordy, taken);
      if (taken) void'(tx_q.pop_front());
      guard++;
    end
    check("send_done", tx_q.size(), keep);
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if ($urandom_range(0, 1) == 0) b[7:4] = 4'h0;
    return b;
  endfunction

  initial begin
    bit taken;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();

    do_reset();

    // Basic frame and its delivery count
    push_frame(8'h34, 8'h12, 8'hAB, 8'h05, 1'b0);
    send_tx(1'b1, 0);
    check("t1_d16", bus.data_16bit, 16'h1234);
    check("t1_d8", bus.data_8bit, 8'hAB);
    check("t1_d4", bus.data_4bit, 4'h5);
    check("t1_vld", bus.out_valid, 1'b1);
    check("t1_fmt", fmt_err, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, taken);
    check("t1_cnt", frame_count, 1);

    // Bad upper nibble on byte 3
    push_frame(8'h01, 8'h02, 8'h03, 8'hF7, 1'b0);
    send_tx(1'b1, 0);
    check("t2_d4", bus.data_4bit, 4'h7);
    check("t2_fmt", fmt_err, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, taken);
    check("t2_fmt_end", fmt_err, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, taken);

    // Back-pressure: second frame stalls at its completing byte, then loads without a bubble
    do_reset();
    push_frame(8'h11, 8'h22, 8'h33, 8'h04, 1'b0);
    send_tx(1'b0, 0);
    push_frame(8'h55, 8'h66, 8'h77, 8'h08, 1'b0);
    send_tx(1'b0, 1);
    cycle(1'b1, tx_q[0], 1'b0, taken);
    check("t3_stall", taken, 1'b0);
    check("t3_hold_d16", bus.data_16bit, 16'h2211);
    cycle(1'b1, tx_q[0], 1'b1, taken);
    check("t3_go", taken, 1'b1);
    if (taken) void'(tx_q.pop_front());
    check("t3_vld", bus.out_valid, 1'b1);
    check("t3_new_d16", bus.data_16bit, 16'h6655);
    cycle(1'b0, 8'h00, 1'b1, taken);

    // Counter wrap over 17 deliveries
    do_reset();
    for (int i = 0; i < 17; i++) push_frame(rand_byte(), rand_byte(), rand_byte(), rand_byte(), 1'b0);
    send_tx(1'b1, 0);
    cycle(1'b0, 8'h00, 1'b1, taken);
    check("t4_wrap", frame_count, 1);

    // Reset mid-frame discards the partial bytes
    push_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0);
    send_tx(1'b1, FLEN - 2);
    tx_q.delete();
    do_reset();
    push_frame(8'h78, 8'h56, 8'h9A, 8'h03, 1'b0);
    send_tx(1'b1, 0);
    check("t5_d16", bus.data_16bit, 16'h5678);
    check("t5_d8", bus.data_8bit, 8'h9A);

`ifdef WIDTH_LANE_CHECKSUM_EN
    do_reset();
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
    send_tx(1'b1, 0);
    check("t6_ck_ok", bus.out_valid, 1'b1);
    cycle(1'b0, 8'h00, 1'b1, taken);
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
    tx_q.push_back(8'h04); tx_q.push_back(8'h00);
    send_tx(1'b1, 0);
    check("t6_chk_err", chk_err, 1'b1);
    check("t6_no_vld", bus.out_valid, 1'b0);
    check("t6_cnt", frame_count, 1);
`endif

    // Random traffic
    do_reset();
    tx_q.delete();
    for (int n = 0; n < 3000; n++) begin
      bit         v;
      bit         ordy;
      logic [7:0] d;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        tx_q.delete();
      end
      if (tx_q.size() == 0)
        push_frame(rand_byte(), rand_byte(), rand_byte(), rand_byte(), $urandom_range(0, 4) == 0);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 9) < 7);
      d    = v ? tx_q[0] : rand_byte();
      cycle(v, d, ordy, taken);
      if (taken) void'(tx_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/width_lane_deserializer.md
# width_lane_deserializer

Receive-side counterpart of the multi-width lane source. Accepts a byte stream over a valid/ready handshake, assembles fixed 4-byte frames, and presents each frame on three parallel lanes: 16-bit, 8-bit and 4-bit. A one-entry output register decouples the byte side from the lane consumer. The block sits between a byte-serial link and any module exposing `data_16bit` / `data_8bit` / `data_4bit` inputs.

## Interface
- `FRAME_CNT_W`, default 16: width of the delivered-frame counter.
- `clk` input 1: sole clock; all state is updated on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: incoming byte.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: the block accepts `in_data` this cycle.
- `data_16bit` output 16: assembled 16-bit lane.
- `data_8bit` output 8: assembled 8-bit lane.
- `data_4bit` output 4: assembled 4-bit lane.
- `out_valid` output 1: the lane outputs hold an undelivered frame.
- `out_ready` input 1: consumer takes the frame.
- `fmt_err` output 1: one-cycle pulse; frame byte 3 had a nonzero upper nibble.
- `frame_count` output FRAME_CNT_W: count of frames delivered; wraps modulo 2^FRAME_CNT_W.

## Operation
- Byte transfer occurs on the cycle where `in_valid && in_ready`. Frame transfer occurs on the cycle where `out_valid && out_ready`.
- FSM states: `B0`, `B1`, `B2`, `B3`, plus `CK` with the macro. Each byte transfer advances one state. After `B3` (or `CK`) the FSM returns to `B0`. A state with no byte transfer holds.
- Byte mapping:
  - `B0` → `data_16bit[7:0]` (little-endian).
  - `B1` → `data_16bit[15:8]`.
  - `B2` → `data_8bit`.
  - `B3` low nibble → `data_4bit`.
- Bytes 0–2 go to a staging register. The lane outputs load only on frame completion, so they stay stable while `out_valid` is high.
- Byte 3 upper nibble nonzero:
  - The frame is still delivered, using the low nibble.
  - `fmt_err` pulses for one cycle, coincident with the cycle `out_valid` rises.
- `in_ready` is 1 in every state except the frame-completing state (`B3`, or `CK`). In that state it equals `!out_valid || out_ready`. This is a combinational path from `out_ready`.
- If a frame completes in the same cycle the previous frame is taken, the new frame loads and `out_valid` stays 1. There is no bubble.
- `frame_count` increments on each frame transfer, not on assembly. It wraps from all-ones to 0.
- Reset mid-frame discards partial bytes and any held frame. The FSM returns to `B0`.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `data_16bit` = 0, `data_8bit` = 0, `data_4bit` = 0.
  - `fmt_err` = 0.
  - `frame_count` = 0.
  - FSM = `B0`.
- Latency: `out_valid` rises the cycle after the final byte transfer.
- Peak throughput: one byte per cycle, so one frame per 4 cycles (5 with the macro), provided `out_ready` is held high.
- `out_valid` falls the cycle after a frame transfer, unless a new frame completes in that same transfer cycle.
- The lane outputs and `out_valid` are registered. `in_ready` is combinational.

## Configuration
- `WIDTH_LANE_CHECKSUM_EN` defined:
  - Adds state `CK`. The fifth byte must equal the XOR of bytes 0–3.
  - Adds output `chk_err` (1 bit, reset 0).
  - On mismatch: the frame is dropped, `out_valid` and `frame_count` are unchanged, `chk_err` pulses one cycle after the `CK` byte, and the FSM returns to `B0`.
  - On match: delivery proceeds as normal.
- Undefined: 4-byte frames, no `CK` state, and no `chk_err` port.

## Test plan
- Reset, then bytes 0x34, 0x12, 0xAB, 0x05 with `out_ready`=1 → one cycle after the last byte: `data_16bit`=0x1234, `data_8bit`=0xAB, `data_4bit`=0x5, `out_valid`=1, `fmt_err`=0. `frame_count`=1 the cycle after the transfer.
- Byte 3 = 0xF7 → `data_4bit`=0x7 and `fmt_err` pulses exactly one cycle, together with `out_valid` rising.
- Hold `out_ready`=0 and stream two frames → the second frame stalls in the completing state with `in_ready`=0 and the first frame stays stable on the outputs. Raise `out_ready` → the second frame loads in the same cycle and `out_valid` stays 1.
- Set `frame_count` near wrap (FRAME_CNT_W=4), deliver 17 frames → count reads 1.
- Assert `rst` after 2 bytes, then send a full frame → the output reflects only the post-reset 4 bytes.
- With `WIDTH_LANE_CHECKSUM_EN`: frame 0x01, 0x02, 0x03, 0x04, checksum 0x04 → delivered. Same frame with checksum 0x00 → `chk_err` pulse, no `out_valid`, `frame_count` unchanged.
